// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch path and the control unit:
// fetch FSM state encoding, base opcode constants, and the reset-time NOP.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // Shift-immediate funct3 codes (slli / srli+srai) carry a 5-bit shamt.
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Purely combinational immediate decoder for the instruction register.
//   ir  : instruction word
//   imm : decoded immediate (I-type sign-extended, shift shamt zero-extended,
//         LUI upper immediate, zero for every other opcode)
// ---------------------------------------------------------------------------
module imm_gen
  import fetch_unit_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_rd_bits;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  // The destination field plays no part in any immediate format decoded here.
  assign unused_rd_bits = ^ir[11:7];

  // NOTE: the default assignment at the top of a combinational block keeps
  // every path driven, so no latch can be inferred.
  always_comb begin
    imm = 32'h0000_0000;
    case (opcode)
      OP_IMM: begin
        if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
          imm = {27'd0, ir[24:20]};
        end else begin
          imm = {{20{ir[31]}}, ir[31:20]};
        end
      end
      OP_LUI:  imm = {ir[31:12], 12'h000};
      default: imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Multi-cycle instruction fetch: on a fetch_go pulse it requests the word at
// pc, waits for imem_ack (bounded by TIMEOUT cycles), latches it into ir and
// advances pc by 4. A timeout returns to IDLE and sets the sticky fetch_err.
//
// Parameters
//   RESET_PC : pc value after reset
//   TIMEOUT  : FETCH cycles allowed without ack before aborting (2..255)
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   fetch_go              : fetch request pulse (ignored while busy)
//   imem_req, imem_addr   : memory read request and address (= pc)
//   imem_ack, imem_rdata  : memory response, honoured only in FETCH
//   pc, ir, ir_valid      : program counter, instruction register, IR valid
//   busy, fetch_err       : fetch in progress, sticky timeout flag
//   opcode..funct7, imm   : fields and immediate decoded from ir
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_go,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_err,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] imm
);

  // Counter value seen in the last FETCH cycle allowed before aborting.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  fetch_state_e state, state_next;
  logic [7:0]   to_cnt;
  logic         load_ir;
  logic         timed_out;

  // Next-state logic. An ack in the final allowed cycle still wins over the
  // timeout.
  always_comb begin
    state_next = state;
    load_ir    = 1'b0;
    timed_out  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fetch_go) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          state_next = ST_DONE;
          load_ir    = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          state_next = ST_IDLE;
          timed_out  = 1'b1;
        end
      end
      ST_DONE: begin
        if (fetch_go) state_next = ST_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers. Reset has priority, so an ack arriving in a reset
  // cycle is dropped along with the fetch it belonged to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      ir        <= NOP_INSN;
      fetch_err <= 1'b0;
      to_cnt    <= 8'd0;
    end else begin
      if (load_ir) begin
        ir <= imem_rdata;
        pc <= pc + 32'd4;
      end
      if (timed_out) fetch_err <= 1'b1;
      // Zero on every way into FETCH; counts only while waiting in FETCH.
      if (state == ST_FETCH && state_next == ST_FETCH) begin
        to_cnt <= to_cnt + 8'd1;
      end else begin
        to_cnt <= 8'd0;
      end
    end
  end

  assign busy      = (state == ST_FETCH);
  assign imem_req  = busy;
  assign imem_addr = pc;
  assign ir_valid  = (state == ST_DONE);

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  imm_gen u_imm_gen (
    .ir  (ir),
    .imm (imm)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Two fetch_unit instances share stimulus: one resets to pc 0, the other to
// 32'hFFFF_FFFC so the wrap to 0 is seen on the first fetch. Expected values
// come from a transaction-level model: each fetch either completes (pc += 4,
// ir = word) or times out (sticky error), with imm derived from the ISA rules.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] PC0_A   = 32'h0000_0000;
  localparam logic [31:0] PC0_B   = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_go;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req, ir_valid, busy, fetch_err;
  logic [31:0] imem_addr, pc, ir, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  logic        b_imem_req, b_ir_valid, b_busy, b_fetch_err;
  logic [31:0] b_imem_addr, b_pc, b_ir, b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_funct3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_pc, exp_pc_b, exp_ir;
  logic        exp_valid, exp_err;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(PC0_A), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_go(fetch_go),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .ir(ir), .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm)
  );

  fetch_unit #(.RESET_PC(PC0_B), .TIMEOUT(TIMEOUT)) dut_b (
    .clk(clk), .rst_n(rst_n), .fetch_go(fetch_go),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(b_pc), .ir(b_ir), .ir_valid(b_ir_valid), .busy(b_busy),
    .fetch_err(b_fetch_err),
    .opcode(b_opcode), .rd(b_rd), .funct3(b_funct3), .rs1(b_rs1), .rs2(b_rs2),
    .funct7(b_funct7), .imm(b_imm)
  );

  // Immediate as the ISA defines it, independent of the RTL decoder.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic [31:0] r;
    r = 32'h0;
    if (w[6:0] == 7'b0010011) begin
      if (w[14:12] == 3'b001 || w[14:12] == 3'b101) r = {27'd0, w[24:20]};
      else r = {{20{w[31]}}, w[31:20]};
    end else if (w[6:0] == 7'b0110111) begin
      r = {w[31:12], 12'h000};
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_pc    = PC0_A;
    exp_pc_b  = PC0_B;
    exp_ir    = 32'h0000_0013;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; fetch_go = 1'b0; imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One fetch transaction: ack after `delay` waiting FETCH cycles, or never if
  // delay >= TIMEOUT. fetch_go is toggled randomly while busy and a stray ack
  // accompanies the go pulse; neither may have any effect.
  task automatic run_fetch(input int delay, input logic [31:0] data, input string tag);
    int   n_busy;
    int   exp_busy;
    logic acked;
    @(negedge clk);
    fetch_go   = 1'b1;
    imem_ack   = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    @(negedge clk);
    fetch_go = 1'b0;
    n_busy   = 0;
    acked    = 1'b0;
    for (int c = 0; c < int'(TIMEOUT) + 4; c++) begin
      if (!busy) break;
      n_busy++;
      n_cmp++;
      if (imem_addr !== exp_pc || imem_req !== 1'b1) begin
        n_bad++;
        $display("FAIL %s addr/req cyc%0d: got %h/%b want %h/1", tag, c, imem_addr, imem_req, exp_pc);
      end
      fetch_go = 1'($urandom_range(0, 1));
      if (c == delay) begin
        imem_ack = 1'b1; imem_rdata = data; acked = 1'b1;
      end else begin
        imem_ack = 1'b0; imem_rdata = $urandom;
      end
      @(negedge clk);
      if (acked) break;
    end
    fetch_go = 1'b0;
    imem_ack = 1'b0;

    if (delay < int'(TIMEOUT)) begin
      exp_pc    = exp_pc + 32'd4;
      exp_pc_b  = exp_pc_b + 32'd4;
      exp_ir    = data;
      exp_valid = 1'b1;
      exp_busy  = delay + 1;
    end else begin
      exp_err   = 1'b1;
      exp_valid = 1'b0;
      exp_busy  = int'(TIMEOUT);
    end

    n_cmp++;
    if (n_busy != exp_busy) begin
      n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, n_busy, exp_busy);
    end
    n_cmp++;
    if (pc !== exp_pc || b_pc !== exp_pc_b) begin
      n_bad++; $display("FAIL %s pc: got %h/%h want %h/%h", tag, pc, b_pc, exp_pc, exp_pc_b);
    end
    n_cmp++;
    if (ir !== exp_ir || b_ir !== exp_ir) begin
      n_bad++; $display("FAIL %s ir: got %h/%h want %h", tag, ir, b_ir, exp_ir);
    end
    n_cmp++;
    if (ir_valid !== exp_valid || busy !== 1'b0 || fetch_err !== exp_err) begin
      n_bad++;
      $display("FAIL %s valid/busy/err: got %b/%b/%b want %b/0/%b", tag, ir_valid, busy, fetch_err, exp_valid, exp_err);
    end
    n_cmp++;
    if ({funct7, rs2, rs1, funct3, rd, opcode} !== exp_ir) begin
      n_bad++; $display("FAIL %s fields: got %h want %h", tag, {funct7, rs2, rs1, funct3, rd, opcode}, exp_ir);
    end
    n_cmp++;
    if (imm !== ref_imm(exp_ir)) begin
      n_bad++; $display("FAIL %s imm: got %h want %h", tag, imm, ref_imm(exp_ir));
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (pc !== PC0_A || b_pc !== PC0_B) begin
      n_bad++; $display("FAIL reset pc: got %h/%h want %h/%h", pc, b_pc, PC0_A, PC0_B);
    end
    n_cmp++;
    if (ir !== 32'h0000_0013 || imm !== 32'h0) begin
      n_bad++; $display("FAIL reset ir/imm: got %h/%h want 00000013/00000000", ir, imm);
    end
    n_cmp++;
    if ({ir_valid, busy, imem_req, fetch_err} !== 4'b0000) begin
      n_bad++; $display("FAIL reset flags: got %b want 0000", {ir_valid, busy, imem_req, fetch_err});
    end
  endtask

  task automatic test_directed();
    run_fetch(0, 32'h0050_0093, "addi");
    n_cmp++;
    if (ir !== 32'h0050_0093 || pc !== 32'd4 || imm !== 32'd5 || rd !== 5'd1 || ir_valid !== 1'b1) begin
      n_bad++; $display("FAIL addi_lit: got ir=%h pc=%h imm=%h rd=%0d v=%b want 00500093/4/5/1/1", ir, pc, imm, rd, ir_valid);
    end
    n_cmp++;
    if (b_pc !== 32'h0) begin
      n_bad++; $display("FAIL pc_wrap: got %h want 00000000", b_pc);
    end
    run_fetch(0, 32'hFFF0_0093, "addi_neg");
    n_cmp++;
    if (imm !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL addi_neg_lit imm: got %h want ffffffff", imm);
    end
    run_fetch(1, 32'h1234_5037, "lui");
    n_cmp++;
    if (imm !== 32'h1234_5000) begin
      n_bad++; $display("FAIL lui_lit imm: got %h want 12345000", imm);
    end
    run_fetch(2, 32'h4030_5093, "srai");
    n_cmp++;
    if (imm !== 32'd3 || funct7 !== 7'b0100000) begin
      n_bad++; $display("FAIL srai_lit: got imm=%h f7=%b want 00000003/0100000", imm, funct7);
    end
  endtask

  task automatic test_delayed_ack();
    run_fetch(3, $urandom, "delay3");
  endtask

  task automatic test_timeout();
    run_fetch(int'(TIMEOUT) + 3, $urandom, "timeout");
    run_fetch(0, 32'h0010_0113, "after_timeout");
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int i = 0; i < 24; i++) begin
      d = $urandom;
      case ($urandom_range(0, 3))
        0: d[6:0] = 7'b0010011;
        1: d[6:0] = 7'b0110111;
        2: d[6:0] = 7'b0110011;
        default: ;
      endcase
      run_fetch(int'($urandom_range(0, 6)), d, "random");
    end
  endtask

  task automatic test_ignore_ack();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_ack = 1'b1; imem_rdata = $urandom;
    end
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp++;
    if (ir !== exp_ir || pc !== exp_pc || busy !== 1'b0 || ir_valid !== exp_valid) begin
      n_bad++; $display("FAIL stray_ack: got ir=%h pc=%h busy=%b v=%b want %h/%h/0/%b", ir, pc, busy, ir_valid, exp_ir, exp_pc, exp_valid);
    end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    fetch_go = 1'b1;
    @(negedge clk);
    fetch_go = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid entry busy: got %b want 1", busy);
    end
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b0;
    model_reset();
    n_cmp++;
    if (pc !== PC0_A || b_pc !== PC0_B || ir !== 32'h0000_0013) begin
      n_bad++; $display("FAIL rst_mid pc/ir: got %h/%h/%h want %h/%h/00000013", pc, b_pc, ir, PC0_A, PC0_B);
    end
    n_cmp++;
    if ({ir_valid, busy, imem_req, fetch_err} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_mid flags: got %b want 0000", {ir_valid, busy, imem_req, fetch_err});
    end
    run_fetch(0, $urandom, "post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; fetch_go = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    model_reset();
    test_reset();
    test_directed();
    test_delayed_ack();
    test_timeout();
    test_random();
    test_ignore_ack();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
